prbs_checker_lfsr: RTL and testbench

Self-synchronising PRBS receiver/checker, the receive-side counterpart of the PRBS generator in the signal path.
- Takes a 1-bit PRBS stream qualified by a per-bit enable.
- Derives its own predictor state from the incoming bits, declares lock, then counts bit errors and received bits.
- Used for loopback BIST of the DAC/ADC path and for digital-output bit-error-rate measurement.

---
 rtl/prbs_checker_lfsr_if.sv | 22 ++
 rtl/prbs_checker_lfsr.sv | 176 +++++++++++++++++
 tb/tb_prbs_checker_lfsr.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_checker_lfsr_if.sv
// Bit-stream and status bundle between a PRBS source and the self-synchronising checker.
// The master drives the stream and controls; the slave returns lock state and counts.
interface prbs_checker_lfsr_if;
    logic        bit_valid;
    logic        rx_bit;
    logic [4:0]  prbs_pn_select_reg;
    logic        clear_counters;
    logic        locked;
    logic        error_pulse;
    logic [31:0] error_count;
    logic [47:0] bit_count;
    logic [15:0] lock_loss_count;

    modport master (
        output bit_valid, rx_bit, prbs_pn_select_reg, clear_counters,
        input  locked, error_pulse, error_count, bit_count, lock_loss_count
    );
    modport slave (
        input  bit_valid, rx_bit, prbs_pn_select_reg, clear_counters,
        output locked, error_pulse, error_count, bit_count, lock_loss_count
    );
endinterface

// File: rtl/prbs_checker_lfsr.sv
// Self-synchronising PRBS checker: learns the predictor state from the incoming stream,
// declares lock, then counts bit errors and checked bits.
module prbs_checker_lfsr #(
    parameter int MAX_PN_ORDER = 31,
    parameter int LOCK_COUNT   = 64,
    parameter int WIN_LEN      = 256,
    parameter int LOSS_ERRS    = 32
) (
    input  logic               dac_clk,
    input  logic               reset_n,
    prbs_checker_lfsr_if.slave bus
);
    localparam int FW = $clog2(MAX_PN_ORDER + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [MAX_PN_ORDER-1:0] hist_reg, hist_next;
    logic [4:0]              sel_reg;
    logic [FW-1:0]           fill_reg, fill_next;
    logic [MW-1:0]           match_reg, match_next;
    logic [WW-1:0]           win_cnt_reg, win_cnt_next;
    logic [EW-1:0]           win_errs_reg, win_errs_next;
    logic                    error_pulse_reg, error_pulse_next;
    logic [31:0]             error_count_reg, error_count_next;
    logic [47:0]             bit_count_reg, bit_count_next;
    logic [15:0]             loss_count_reg, loss_count_next;

    logic [FW-1:0]           order;
    logic [MAX_PN_ORDER-1:0] tap_mask;
    logic [MAX_PN_ORDER-1:0] hist_shift;
    logic                    pred;
    logic                    mismatch;
    logic                    new_bit;

    always_comb begin
        order    = FW'(3);
        tap_mask = MAX_PN_ORDER'(31'h3);
        case (sel_reg)
            5'd0:    begin order = FW'(3);  tap_mask = MAX_PN_ORDER'(31'h5);        end
            5'd1:    begin order = FW'(5);  tap_mask = MAX_PN_ORDER'(31'h9);        end
            5'd2:    begin order = FW'(7);  tap_mask = MAX_PN_ORDER'(31'h11);       end
            5'd3:    begin order = FW'(9);  tap_mask = MAX_PN_ORDER'(31'h21);       end
            5'd4:    begin order = FW'(11); tap_mask = MAX_PN_ORDER'(31'h201);      end
            5'd5:    begin order = FW'(13); tap_mask = MAX_PN_ORDER'(31'h1601);     end
            5'd6:    begin order = FW'(15); tap_mask = MAX_PN_ORDER'(31'h4001);     end
            5'd7:    begin order = FW'(17); tap_mask = MAX_PN_ORDER'(31'h4001);     end
            5'd8:    begin order = FW'(19); tap_mask = MAX_PN_ORDER'(31'h64001);    end
            5'd9:    begin order = FW'(21); tap_mask = MAX_PN_ORDER'(31'h80001);    end
            5'd10:   begin order = FW'(23); tap_mask = MAX_PN_ORDER'(31'h40001);    end
            5'd11:   begin order = FW'(25); tap_mask = MAX_PN_ORDER'(31'h400001);   end
            5'd12:   begin order = FW'(27); tap_mask = MAX_PN_ORDER'(31'h6400001);  end
            5'd13:   begin order = FW'(29); tap_mask = MAX_PN_ORDER'(31'h8000001);  end
            5'd14:   begin order = FW'(31); tap_mask = MAX_PN_ORDER'(31'h10000001); end
            default: begin order = FW'(3);  tap_mask = MAX_PN_ORDER'(31'h3);        end
        endcase
    end

    assign pred     = ^(hist_reg & tap_mask);
    assign mismatch = bus.rx_bit ^ pred;
    // Once locked the predictor free-runs, so a single line error is counted exactly once.
    assign new_bit  = (state_reg == LOCKED) ? pred : bus.rx_bit;

    // Bits at or above the order are always zero, so a plain downshift keeps them clear.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PN_ORDER; gi++) begin : g_shift
            if (gi == MAX_PN_ORDER - 1) begin : g_top
                assign hist_shift[gi] = (order == FW'(gi + 1)) ? new_bit : 1'b0;
            end else begin : g_mid
                assign hist_shift[gi] = (order == FW'(gi + 1)) ? new_bit : hist_reg[gi + 1];
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        hist_next        = hist_reg;
        fill_next        = fill_reg;
        match_next       = match_reg;
        win_cnt_next     = win_cnt_reg;
        win_errs_next    = win_errs_reg;
        error_pulse_next = 1'b0;
        error_count_next = error_count_reg;
        bit_count_next   = bit_count_reg;
        loss_count_next  = loss_count_reg;

        if (bus.prbs_pn_select_reg != sel_reg) begin
            state_next    = HUNT;
            hist_next     = '0;
            fill_next     = '0;
            match_next    = '0;
            win_cnt_next  = '0;
            win_errs_next = '0;
        end else if (bus.bit_valid) begin
            hist_next = hist_shift;
            if (state_reg == HUNT) begin
                if (fill_reg != order) begin
                    fill_next = fill_reg + 1'b1;
                end else if (!mismatch && (hist_reg != '0)) begin
                    if (match_reg == MW'(LOCK_COUNT - 1)) begin
                        state_next = LOCKED;
                        match_next = '0;
                    end else begin
                        match_next = match_reg + 1'b1;
                    end
                end else begin
                    match_next = '0;
                end
            end else begin
                if (bit_count_reg != '1) bit_count_next = bit_count_reg + 1'b1;
                win_cnt_next = win_cnt_reg + 1'b1;
                if (mismatch) begin
                    error_pulse_next = 1'b1;
                    if (error_count_reg != '1) error_count_next = error_count_reg + 1'b1;
                    win_errs_next = win_errs_reg + 1'b1;
                end
                if (win_errs_next == EW'(LOSS_ERRS)) begin
                    state_next    = HUNT;
                    hist_next     = '0;
                    fill_next     = '0;
                    match_next    = '0;
                    win_cnt_next  = '0;
                    win_errs_next = '0;
                    if (loss_count_reg != '1) loss_count_next = loss_count_reg + 1'b1;
                end else if (win_cnt_next == WW'(WIN_LEN)) begin
                    win_cnt_next  = '0;
                    win_errs_next = '0;
                end
            end
        end

        if (bus.clear_counters) begin
            error_count_next = '0;
            bit_count_next   = '0;
            loss_count_next  = '0;
        end
    end

    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= HUNT;
            hist_reg        <= '0;
            sel_reg         <= '0;
            fill_reg        <= '0;
            match_reg       <= '0;
            win_cnt_reg     <= '0;
            win_errs_reg    <= '0;
            error_pulse_reg <= 1'b0;
            error_count_reg <= '0;
            bit_count_reg   <= '0;
            loss_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            hist_reg        <= hist_next;
            sel_reg         <= bus.prbs_pn_select_reg;
            fill_reg        <= fill_next;
            match_reg       <= match_next;
            win_cnt_reg     <= win_cnt_next;
            win_errs_reg    <= win_errs_next;
            error_pulse_reg <= error_pulse_next;
            error_count_reg <= error_count_next;
            bit_count_reg   <= bit_count_next;
            loss_count_reg  <= loss_count_next;
        end
    end

    assign bus.locked          = (state_reg == LOCKED);
    assign bus.error_pulse     = error_pulse_reg;
    assign bus.error_count     = error_count_reg;
    assign bus.bit_count       = bit_count_reg;
    assign bus.lock_loss_count = loss_count_reg;
endmodule

// File: tb/tb_prbs_checker_lfsr.sv
// Directed bench for prbs_checker_lfsr: lock, single error, loss of lock, all-zero
// rejection, order switch, gapped valid, clear priority and asynchronous reset.
module tb_prbs_checker_lfsr;
    logic dac_clk = 1'b0;
    logic reset_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_seen   = 0;
    int lock_seen    = 0;

    bit          seq[$];
    int          gen_n;
    logic [30:0] gen_mask;

    prbs_checker_lfsr_if bus ();

    prbs_checker_lfsr dut (
        .dac_clk (dac_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #2 dac_clk = ~dac_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Reference stream: s[k] for k < N is the seed 1,0,0..; afterwards the tap recurrence.
    task automatic set_order(input logic [4:0] sel);
        logic [30:0] m;
        m = '0;
        case (sel)
            5'd0:    begin gen_n = 3;  m[2] = 1'b1; end
            5'd1:    begin gen_n = 5;  m[3] = 1'b1; end
            5'd2:    begin gen_n = 7;  m[4] = 1'b1; end
            5'd3:    begin gen_n = 9;  m[5] = 1'b1; end
            5'd4:    begin gen_n = 11; m[9] = 1'b1; end
            5'd5:    begin gen_n = 13; m[12] = 1'b1; m[10] = 1'b1; m[9] = 1'b1; end
            5'd6:    begin gen_n = 15; m[14] = 1'b1; end
            5'd14:   begin gen_n = 31; m[28] = 1'b1; end
            default: begin gen_n = 3;  m[1] = 1'b1; end
        endcase
        m[0] = 1'b1;
        gen_mask = m;
        seq.delete();
        bus.prbs_pn_select_reg = sel;
    endtask

    task automatic gen_bit(output bit b);
        int k;
        k = seq.size();
        if (k < gen_n) begin
            b = (k == 0);
        end else begin
            b = 1'b0;
            for (int t = 0; t < gen_n; t++)
                if (gen_mask[t]) b ^= seq[k - gen_n + t];
        end
        seq.push_back(b);
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        bus.bit_valid      = v;
        bus.rx_bit         = b;
        bus.clear_counters = clr;
        @(posedge dac_clk);
        #1;
        if (bus.error_pulse) pulse_seen++;
        if (bus.locked) lock_seen++;
    endtask

    task automatic send_clean(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
    endtask

    task automatic send_flip();
        bit b;
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
    endtask

    // One valid bit followed by three idle cycles carrying junk on rx_bit.
    task automatic send_gapped(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            for (int j = 0; j < 3; j++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_locked"}, bus.locked, 0);
        check_val({tag, "_pulse"},  bus.error_pulse, 0);
        check_val({tag, "_errs"},   bus.error_count, 0);
        check_val({tag, "_bits"},   bus.bit_count, 0);
        check_val({tag, "_loss"},   bus.lock_loss_count, 0);
    endtask

    initial begin
        bus.bit_valid      = 1'b0;
        bus.rx_bit         = 1'b0;
        bus.clear_counters = 1'b0;
        set_order(5'd2);
        repeat (3) @(posedge dac_clk);
        #1;
        check_all_zero("reset");
        @(negedge dac_clk) reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // PN7 clean stream: lock after 7 fill + 64 matches
        send_clean(70);
        check_val("pn7_prelock", bus.locked, 0);
        send_clean(1);
        check_val("pn7_lock", bus.locked, 1);
        pulse_seen = 0;
        send_clean(9929);
        check_val("pn7_errs", bus.error_count, 0);
        check_val("pn7_bits", bus.bit_count, 9929);
        check_val("pn7_pulses", pulse_seen, 0);
        check_val("pn7_still_locked", bus.locked, 1);

        // PN15, one flipped bit
        set_order(5'd6);
        step(1'b0, 1'b0, 1'b0);
        check_val("sel_chg_unlock", bus.locked, 0);
        check_val("sel_chg_bits_hold", bus.bit_count, 9929);
        check_val("sel_chg_loss", bus.lock_loss_count, 0);
        step(1'b0, 1'b0, 1'b1);
        check_val("clear_bits", bus.bit_count, 0);
        send_clean(78);
        check_val("pn15_prelock", bus.locked, 0);
        send_clean(1);
        check_val("pn15_lock", bus.locked, 1);
        send_clean(20);
        pulse_seen = 0;
        send_flip();
        check_val("pn15_pulse_hi", bus.error_pulse, 1);
        check_val("pn15_errs1", bus.error_count, 1);
        send_clean(1);
        check_val("pn15_pulse_lo", bus.error_pulse, 0);
        send_clean(100);
        check_val("pn15_errs_final", bus.error_count, 1);
        check_val("pn15_pulses", pulse_seen, 1);
        check_val("pn15_locked", bus.locked, 1);
        check_val("pn15_bits", bus.bit_count, 122);

        // PN9, 32 errors within one window force loss of lock
        set_order(5'd3);
        step(1'b0, 1'b0, 1'b1);
        send_clean(73);
        check_val("pn9_lock", bus.locked, 1);
        for (int i = 0; i < 62; i++) begin
            if (i % 2 == 0) send_flip();
            else send_clean(1);
        end
        check_val("pn9_31err_locked", bus.locked, 1);
        check_val("pn9_31err_count", bus.error_count, 31);
        send_flip();
        check_val("pn9_loss_unlock", bus.locked, 0);
        check_val("pn9_loss_count", bus.lock_loss_count, 1);
        check_val("pn9_errs32", bus.error_count, 32);
        send_clean(72);
        check_val("pn9_prerelock", bus.locked, 0);
        send_clean(1);
        check_val("pn9_relock", bus.locked, 1);
        check_val("pn9_errs_hold", bus.error_count, 32);
        check_val("pn9_bits", bus.bit_count, 63);

        // All-zero stream must never lock
        set_order(5'd4);
        step(1'b0, 1'b0, 1'b0);
        set_order(5'd3);
        step(1'b0, 1'b0, 1'b0);
        lock_seen = 0;
        repeat (2000) step(1'b1, 1'b0, 1'b0);
        check_val("zeros_lock_cycles", lock_seen, 0);

        // PN7 lock, then switch to PN13
        set_order(5'd2);
        step(1'b0, 1'b0, 1'b0);
        send_clean(71);
        check_val("pn7b_lock", bus.locked, 1);
        set_order(5'd5);
        step(1'b0, 1'b0, 1'b0);
        check_val("pn13_switch_unlock", bus.locked, 0);
        check_val("pn13_switch_loss", bus.lock_loss_count, 1);
        send_clean(76);
        check_val("pn13_prelock", bus.locked, 0);
        send_clean(1);
        check_val("pn13_lock", bus.locked, 1);
        check_val("pn13_loss", bus.lock_loss_count, 1);

        // PN31 with 1-of-4 valid, clear vs error, async reset
        set_order(5'd14);
        step(1'b0, 1'b0, 1'b0);
        send_gapped(94);
        check_val("pn31_prelock", bus.locked, 0);
        send_gapped(1);
        check_val("pn31_lock", bus.locked, 1);
        check_val("pn31_bits_at_lock", bus.bit_count, 63);
        send_gapped(8);
        check_val("pn31_bits_gapped", bus.bit_count, 71);
        begin
            bit b;
            gen_bit(b);
            step(1'b1, ~b, 1'b1);
        end
        check_val("clr_err_pulse", bus.error_pulse, 1);
        check_val("clr_err_errs", bus.error_count, 0);
        check_val("clr_err_bits", bus.bit_count, 0);
        check_val("clr_err_loss", bus.lock_loss_count, 0);
        check_val("clr_err_locked", bus.locked, 1);
        bus.clear_counters = 1'b0;
        send_gapped(4);
        check_val("pre_rst_bits", bus.bit_count, 4);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge dac_clk) reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_val("post_rst_locked", bus.locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
